// File: rtl/md_force_pkg.sv
// Shared types for the MD force distributor: packet layout, FSM states, slot indexing.
// Widths here are the default build; the top recomputes its own from parameters.
package md_force_pkg;

    localparam int DEF_DATA_WIDTH        = 32;
    localparam int DEF_CELL_ID_WIDTH     = 3;
    localparam int DEF_PARTICLE_ID_WIDTH = 7;
    localparam int DEF_ID_WIDTH          = 3*DEF_CELL_ID_WIDTH + DEF_PARTICLE_ID_WIDTH;

    typedef struct packed {
        logic [DEF_ID_WIDTH-1:0]   id;
        logic [DEF_DATA_WIDTH-1:0] fz;
        logic [DEF_DATA_WIDTH-1:0] fy;
        logic [DEF_DATA_WIDTH-1:0] fx;
    } wb_pkt_t;

    typedef enum logic [1:0] {ACTIVE, DRAIN, WB_REF, DONE} fd_state_e;

    function automatic int unsigned slot_idx(input int unsigned phase, input int unsigned filt,
                                             input int unsigned num_filter);
        return phase*num_filter + filt;
    endfunction

endpackage

// File: rtl/force_wb_fifo.sv
// Synchronous FIFO with full/empty flags; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module force_wb_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/force_distributor_mp.sv
// Multi-phase force distributor: neighbour forces via elastic FIFO, ref forces held in slots
// and flushed on start_wb. FORCE_DIST_OVERFLOW_CHECK_EN enables the sticky overflow flag.
module force_distributor_mp
    import md_force_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int CELL_ID_WIDTH     = 3,
    parameter int PARTICLE_ID_WIDTH = 7,
    parameter int NUM_FILTER        = 7,
    parameter int NUM_PHASES        = 2,
    parameter int NB_FIFO_DEPTH     = 8,
    parameter int WAIT_CYCLES       = 5,
    parameter int ID_WIDTH          = 3*CELL_ID_WIDTH + PARTICLE_ID_WIDTH,
    parameter int WB_WIDTH          = ID_WIDTH + 3*DATA_WIDTH
)(
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start_wb,
    input  logic [$clog2(NUM_PHASES)-1:0]         ref_phase,
    input  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_force_x,
    input  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_force_y,
    input  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_force_z,
    input  logic [NUM_FILTER-1:0][ID_WIDTH-1:0]   ref_id,
    input  logic [NUM_FILTER-1:0]                 ref_force_valid,
    input  logic [DATA_WIDTH-1:0]                 force_x,
    input  logic [DATA_WIDTH-1:0]                 force_y,
    input  logic [DATA_WIDTH-1:0]                 force_z,
    input  logic [ID_WIDTH-1:0]                   nb_id,
    input  logic                                  force_valid,
    input  logic                                  ready,
    output logic [WB_WIDTH-1:0]                   wb_out,
    output logic                                  wb_valid,
    output logic                                  all_ref_wb_issued,
    output logic                                  overflow
);
    localparam int NUM_SLOTS = NUM_PHASES*NUM_FILTER;
    localparam int SW        = $clog2(NUM_SLOTS);
    localparam int IW        = $clog2(NUM_SLOTS+1);
    localparam int QW        = $clog2(WAIT_CYCLES+1);
    localparam logic [IW-1:0] SLOT_END = IW'(NUM_SLOTS);
    localparam logic [QW-1:0] QUIET_MAX = QW'(WAIT_CYCLES);

    fd_state_e state, state_nxt;

    logic [NUM_SLOTS-1:0][WB_WIDTH-1:0]   slot_pkt;
    logic [NUM_SLOTS-1:0]                 slot_vld;
    logic [NUM_FILTER-1:0][WB_WIDTH-1:0]  ref_pkt;
    logic [NUM_FILTER-1:0][SW-1:0]        cap_idx;
    logic [IW-1:0]                        idx;
    logic [SW-1:0]                        scan_idx;
    logic [QW-1:0]                        qcnt;
    logic [WB_WIDTH-1:0]                  fifo_dout;
    logic fifo_full, fifo_empty;
    logic ld_en, nb_en, scan_en, cap_en, phase_ok;

    assign ld_en    = !wb_valid || ready;
    assign phase_ok = 32'(ref_phase) < NUM_PHASES;
    assign cap_en   = nb_en && phase_ok;
    assign scan_idx = idx[SW-1:0];

    for (genvar i = 0; i < NUM_FILTER; i++) begin : g_ref
        assign ref_pkt[i] = {ref_id[i], ref_force_z[i], ref_force_y[i], ref_force_x[i]};
        assign cap_idx[i] = SW'(slot_idx(int'(ref_phase), i, NUM_FILTER));
    end

    force_wb_fifo #(.WIDTH(WB_WIDTH), .DEPTH(NB_FIFO_DEPTH)) u_nb_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (force_valid && nb_en),
        .pop   (nb_en && ld_en),
        .din   ({nb_id, force_z, force_y, force_x}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ACTIVE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ACTIVE: if (start_wb) state_nxt = DRAIN;
            DRAIN:  if (qcnt == QUIET_MAX) state_nxt = WB_REF;
            WB_REF: if (idx == SLOT_END && ld_en) state_nxt = DONE;
            DONE:   state_nxt = ACTIVE;
            default: state_nxt = ACTIVE;
        endcase
    end

    always_comb begin
        nb_en             = 1'b1;
        scan_en           = 1'b0;
        all_ref_wb_issued = 1'b0;
        case (state)
            WB_REF: begin
                nb_en   = 1'b0;
                scan_en = ld_en && (idx != SLOT_END);
            end
            DONE:    all_ref_wb_issued = 1'b1;
            default: ;
        endcase
    end

    // Quiet counter runs only in DRAIN; scan index is primed to 0 before WB_REF.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qcnt <= '0;
            idx  <= '0;
        end else begin
            case (state)
                DRAIN: begin
                    idx <= '0;
                    if (force_valid || !fifo_empty || wb_valid) qcnt <= '0;
                    else                                        qcnt <= qcnt + 1'b1;
                end
                WB_REF:  if (scan_en) idx <= idx + 1'b1;
                default: qcnt <= '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_vld <= '0;
        end else if (scan_en) begin
            slot_vld[scan_idx] <= 1'b0;
        end else if (cap_en) begin
            for (int i = 0; i < NUM_FILTER; i++)
                if (ref_force_valid[i]) slot_vld[cap_idx[i]] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cap_en)
            for (int i = 0; i < NUM_FILTER; i++)
                if (ref_force_valid[i]) slot_pkt[cap_idx[i]] <= ref_pkt[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_out   <= '0;
            wb_valid <= 1'b0;
        end else if (ld_en) begin
            if (!nb_en) begin
                if (scan_en && slot_vld[scan_idx]) begin
                    wb_out   <= slot_pkt[scan_idx];
                    wb_valid <= 1'b1;
                end else begin
                    wb_valid <= 1'b0;
                end
            end else if (!fifo_empty) begin
                wb_out   <= fifo_dout;
                wb_valid <= 1'b1;
            end else begin
                wb_valid <= 1'b0;
            end
        end
    end

`ifdef FORCE_DIST_OVERFLOW_CHECK_EN
    logic drop;
    // A full FIFO always has the output register occupied, so a pop happens iff ld_en.
    assign drop = force_valid && (!nb_en || (fifo_full && !ld_en));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       overflow <= 1'b0;
        else if (drop) overflow <= 1'b1;
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!rst && drop) $error("%m: neighbour force dropped");
    end
`endif
`else
    logic unused_full;
    assign unused_full = fifo_full;
    assign overflow    = 1'b0;
`endif

endmodule
